// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter:
// FSM encoding, requester ids and address alignment.
package dm_arb_pkg;

    localparam logic IDLE   = 1'b0;
    localparam logic ACCESS = 1'b1;

    localparam logic REQ_PIPE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(
        input logic [31:0] addr
    );
        return addr & ADDR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick2.sv
// Two-way round-robin selector used when the arbiter is idle.
// On a tie the requester that did not own the last grant wins.
module rr_pick2
    import dm_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = REQ_PIPE;
        unique case (1'b1)
            (req0 && req1):  grant_id = ~last_owner;
            (req1 && !req0): grant_id = REQ_DBG;
            default:         grant_id = REQ_PIPE;
        endcase
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter/sequencer between the MEM stage and the debug port
// in front of the single-port data memory, with wait states.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             last_owner;
    logic             lat_we;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;

    logic grant_valid;
    logic grant_id;
    logic final_cyc;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign final_cyc = (state == ACCESS)
                    && (cnt == CNT_W'(WAIT_CYCLES));

    // Requests are only looked at in IDLE; ACCESS runs on the latched copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= REQ_DBG;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state      <= ACCESS;
                        cnt        <= '0;
                        last_owner <= grant_id;
                        lat_we     <= grant_id ? we1 : we0;
                        lat_addr   <= grant_id ? addr1 : addr0;
                        lat_wdata  <= grant_id ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (final_cyc) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Everything below is decoded from state, so reset kills mem_we at once.
    always_comb begin
        busy      = (state == ACCESS);
        owner     = last_owner;
        mem_we    = final_cyc & lat_we;
        mem_addr  = busy ? word_align(lat_addr) : '0;
        mem_wdata = busy ? lat_wdata : '0;
        ack0      = final_cyc & (last_owner == REQ_PIPE);
        ack1      = final_cyc & (last_owner == REQ_DBG);
        rdata0    = ack0 ? mem_rdata : '0;
        rdata1    = ack1 ? mem_rdata : '0;
    end

endmodule
